// File: rtl/adder_output_scheduler_if.sv
// Requester handshake plus Avalon-MM PIO master bundle for adder_output_scheduler.
// master = scheduler side, slave = requesters and PIO slave side.
interface adder_output_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 3
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      busy;
  logic [DATA_W-1:0]         cur_value;
  logic                      err;
  logic                      err_clr;
  logic [1:0]                avm_address;
  logic                      avm_chipselect;
  logic                      avm_write_n;
  logic [31:0]               avm_writedata;
  logic [31:0]               avm_readdata;

  modport master (
    input  req, req_data, err_clr, avm_readdata,
    output ack, busy, cur_value, err,
           avm_address, avm_chipselect, avm_write_n, avm_writedata
  );

  modport slave (
    output req, req_data, err_clr, avm_readdata,
    input  ack, busy, cur_value, err,
           avm_address, avm_chipselect, avm_write_n, avm_writedata
  );
endinterface

// File: rtl/adder_output_scheduler.sv
// Round-robin scheduler serialising requester writes to a PIO slave, with a hold time per value.
// Define ADDER_OUTPUT_SCHEDULER_READBACK_EN to add a readback cycle and sticky err flag.
module adder_output_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 3,
  parameter int HOLD_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  adder_output_scheduler_if.master bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef ADDER_OUTPUT_SCHEDULER_READBACK_EN
  typedef enum logic [1:0] {IDLE, WRITE, READ, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;
`endif

  state_t            state_reg;
  logic [GW-1:0]     last_grant_reg;
  logic [GW-1:0]     grant_reg;
  logic [DATA_W-1:0] value_reg;
  logic [NUM_REQ-1:0] ack_reg;
  logic [DATA_W-1:0] cur_value_reg;
  logic              err_reg;
  logic [15:0]       hold_cnt_reg;
  logic              cs_reg;
  logic              write_n_reg;
  logic [31:0]       writedata_reg;

  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic              grant_found;
  logic [GW-1:0]     grant_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Walk forward from last_grant+1 with wrap; the first live request wins.
  always_comb begin
    logic [GW-1:0] cand;
    grant_found = 1'b0;
    grant_next  = '0;
    cand        = last_grant_reg;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == GW'(NUM_REQ-1)) ? '0 : cand + 1'b1;
      if (!grant_found && bus.req[cand]) begin
        grant_found = 1'b1;
        grant_next  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= GW'(NUM_REQ-1);
      grant_reg      <= '0;
      value_reg      <= '0;
      ack_reg        <= '0;
      cur_value_reg  <= '0;
      err_reg        <= 1'b0;
      hold_cnt_reg   <= '0;
      cs_reg         <= 1'b0;
      write_n_reg    <= 1'b1;
      writedata_reg  <= '0;
    end else begin
      ack_reg       <= '0;
      cs_reg        <= 1'b0;
      write_n_reg   <= 1'b1;
      writedata_reg <= '0;
`ifdef ADDER_OUTPUT_SCHEDULER_READBACK_EN
      if (bus.err_clr)
        err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            grant_reg      <= grant_next;
            last_grant_reg <= grant_next;
            value_reg      <= data_arr[grant_next];
            cs_reg         <= 1'b1;
            write_n_reg    <= 1'b0;
            writedata_reg  <= 32'(data_arr[grant_next]);
            state_reg      <= WRITE;
          end
        end
        WRITE: begin
          cur_value_reg <= value_reg;
`ifdef ADDER_OUTPUT_SCHEDULER_READBACK_EN
          cs_reg    <= 1'b1;
          state_reg <= READ;
`else
          ack_reg      <= NUM_REQ'(1) << grant_reg;
          hold_cnt_reg <= 16'(HOLD_CYCLES-1);
          state_reg    <= HOLD;
`endif
        end
`ifdef ADDER_OUTPUT_SCHEDULER_READBACK_EN
        READ: begin
          // Assigned after the err_clr branch so a mismatch beats a clear.
          if (bus.avm_readdata[DATA_W-1:0] != value_reg)
            err_reg <= 1'b1;
          ack_reg      <= NUM_REQ'(1) << grant_reg;
          hold_cnt_reg <= 16'(HOLD_CYCLES-1);
          state_reg    <= HOLD;
        end
`endif
        HOLD: begin
          if (hold_cnt_reg == 16'd0)
            state_reg <= IDLE;
          else
            hold_cnt_reg <= hold_cnt_reg - 16'd1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifndef ADDER_OUTPUT_SCHEDULER_READBACK_EN
  logic unused_sig;
  assign unused_sig = ^{bus.err_clr, bus.avm_readdata};
`endif

  assign bus.ack            = ack_reg;
  assign bus.busy           = (state_reg != IDLE);
  assign bus.cur_value      = cur_value_reg;
  assign bus.err            = err_reg;
  assign bus.avm_address    = 2'b00;
  assign bus.avm_chipselect = cs_reg;
  assign bus.avm_write_n    = write_n_reg;
  assign bus.avm_writedata  = writedata_reg;
endmodule

// File: tb/tb_adder_output_scheduler.sv
// Directed bench for adder_output_scheduler: vector table plus round-robin, drop, reset and readback sequences.
module tb_adder_output_scheduler;
  localparam int NR = 4;
  localparam int DW = 3;
  localparam int HC = 4;
`ifdef ADDER_OUTPUT_SCHEDULER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic bad;
  logic [31:0] slave_reg;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  adder_output_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  adder_output_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .HOLD_CYCLES(HC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // PIO slave: stores writes, optionally returns a corrupted readback.
  always_ff @(posedge clk) begin
    if (reset)
      slave_reg <= '0;
    else if (bus.avm_chipselect && !bus.avm_write_n)
      slave_reg <= bus.avm_writedata;
  end
  assign bus.avm_readdata = bad ? 32'h0 : slave_reg;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] data;
    int          grant;
    logic [2:0]  value;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; bus.req = '0; bus.req_data = '0; bus.err_clr = 1'b0; bad = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy && n < 50) begin @(negedge clk); n++; end
    check({nm, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    while (bus.ack == 4'd0 && n < 30) begin @(negedge clk); n++; end
    check({nm, "_ack_seen"}, 32'(bus.ack != 4'd0), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int n;
    @(negedge clk);
    bus.req = v.req; bus.req_data = v.data;
    @(negedge clk);
    check($sformatf("v%0d_strobe", id), {30'd0, bus.avm_chipselect, bus.avm_write_n}, 32'b10);
    check($sformatf("v%0d_wdata", id), bus.avm_writedata, 32'(v.value));
    check($sformatf("v%0d_addr", id), 32'(bus.avm_address), 32'd0);
    bus.req = '0;
`ifdef ADDER_OUTPUT_SCHEDULER_READBACK_EN
    @(negedge clk);
    check($sformatf("v%0d_rdstrobe", id), {30'd0, bus.avm_chipselect, bus.avm_write_n}, 32'b11);
`endif
    @(negedge clk);
    check($sformatf("v%0d_ack", id), 32'(bus.ack), 32'(4'b0001 << v.grant));
    check($sformatf("v%0d_cur", id), 32'(bus.cur_value), 32'(v.value));
    check($sformatf("v%0d_bus_idle", id), {30'd0, bus.avm_chipselect, bus.avm_write_n}, 32'b01);
    n = 0;
    while (bus.busy && n < 50) begin @(negedge clk); n++; end
    check($sformatf("v%0d_hold_len", id), 32'(n), 32'(HC));
    $display("vec %0d req=%b grant=%0d value=%0d", id, v.req, v.grant, v.value);
  endtask

  task automatic count_activity(input int cycles, output int strobes, output int acks);
    strobes = 0; acks = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.avm_chipselect && !bus.avm_write_n) strobes++;
      if (bus.ack != 4'd0) acks++;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int wcyc[5];
    int wval[5];
    int agr[5];
    int exp_g[5];
    int nw, na, cyc, s, a, a2;

    vecs[0] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}, 0, 3'd5};
    vecs[1] = '{4'b1111, {3'd6, 3'd3, 3'd2, 3'd1}, 1, 3'd2};
    vecs[2] = '{4'b1001, {3'd7, 3'd0, 3'd0, 3'd1}, 3, 3'd7};
    vecs[3] = '{4'b1001, {3'd7, 3'd0, 3'd0, 3'd4}, 0, 3'd4};
    vecs[4] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, 0, 3'd3};
    vecs[5] = '{4'b0100, {3'd0, 3'd6, 3'd0, 3'd0}, 2, 3'd6};
    vecs[6] = '{4'b0010, {3'd0, 3'd0, 3'd5, 3'd0}, 1, 3'd5};
    vecs[7] = '{4'b1110, {3'd3, 3'd1, 3'd2, 3'd0}, 2, 3'd1};

    reset = 1'b1; bus.req = '0; bus.req_data = '0; bus.err_clr = 1'b0; bad = 1'b0;
    apply_reset();
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_cur", 32'(bus.cur_value), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_bus", {30'd0, bus.avm_chipselect, bus.avm_write_n}, 32'b01);
    check("rst_wdata", bus.avm_writedata, 32'd0);
    $display("reset state checked");

    foreach (vecs[i]) run_vec(vecs[i], i);
    check("vec_err", 32'(bus.err), 32'd0);

    // All four requesters held: grants rotate 0,1,2,3,0 at a fixed write period.
    apply_reset();
    exp_g = '{0, 1, 2, 3, 0};
    @(negedge clk);
    bus.req = 4'b1111; bus.req_data = {3'd4, 3'd3, 3'd2, 3'd1};
    nw = 0; na = 0; cyc = 0;
    while (na < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.avm_chipselect && !bus.avm_write_n && nw < 5) begin
        wcyc[nw] = cyc; wval[nw] = int'(bus.avm_writedata); nw++;
      end
      if (bus.ack != 4'd0) begin agr[na] = int'(bus.ack); na++; end
    end
    bus.req = '0;
    check("rr_ack_count", 32'(na), 32'd5);
    check("rr_write_count", 32'(nw), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_ack%0d", i), 32'(agr[i]), 32'(1 << exp_g[i]));
      check($sformatf("rr_wdata%0d", i), 32'(wval[i]), 32'(exp_g[i] + 1));
      if (i > 0)
        check($sformatf("rr_period%0d", i), 32'(wcyc[i] - wcyc[i-1]), 32'(HC + 2 + RB));
      $display("rr grant %0d ack=%b wdata=%0d cycle=%0d", i, agr[i][3:0], wval[i], wcyc[i]);
    end
    wait_idle("rr");

    // Requester 2 pulses only during HOLD and must be ignored.
    apply_reset();
    @(negedge clk);
    bus.req = 4'b0001; bus.req_data = {3'd0, 3'd6, 3'd0, 3'd5};
    wait_ack("drop");
    bus.req = '0;
    @(negedge clk); bus.req = 4'b0100;
    @(negedge clk); bus.req = 4'b0000;
    count_activity(20, s, a);
    check("drop_strobes", 32'(s), 32'd0);
    check("drop_acks", 32'(a), 32'd0);
    $display("pulse during hold: strobes=%0d acks=%0d", s, a);

    // Reset during HOLD.
    apply_reset();
    @(negedge clk);
    bus.req = 4'b0001; bus.req_data = {3'd0, 3'd0, 3'd0, 3'd6};
    wait_ack("rsth");
    bus.req = '0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("rsth_busy", 32'(bus.busy), 32'd0);
    check("rsth_ack", 32'(bus.ack), 32'd0);
    check("rsth_bus", {30'd0, bus.avm_chipselect, bus.avm_write_n}, 32'b01);
    check("rsth_wdata", bus.avm_writedata, 32'd0);
    check("rsth_cur", 32'(bus.cur_value), 32'd0);
    reset = 1'b0;
    $display("reset during hold checked");

    // Reset during WRITE: transaction abandoned, no ack, no further bus cycle.
    @(negedge clk);
    bus.req = 4'b0001; bus.req_data = {3'd0, 3'd0, 3'd0, 3'd7};
    @(negedge clk);
    check("rstw_strobe", {30'd0, bus.avm_chipselect, bus.avm_write_n}, 32'b10);
    reset = 1'b1; bus.req = '0;
    @(negedge clk);
    check("rstw_busy", 32'(bus.busy), 32'd0);
    check("rstw_ack", 32'(bus.ack), 32'd0);
    check("rstw_bus", {30'd0, bus.avm_chipselect, bus.avm_write_n}, 32'b01);
    check("rstw_cur", 32'(bus.cur_value), 32'd0);
    reset = 1'b0;
    count_activity(12, s, a);
    check("rstw_strobes", 32'(s), 32'd0);
    check("rstw_acks", 32'(a), 32'd0);
    $display("reset during write checked: strobes=%0d acks=%0d", s, a);

    // Corrupted readback of 7.
    apply_reset();
    bad = 1'b1;
    @(negedge clk);
    bus.req = 4'b0001; bus.req_data = {3'd0, 3'd0, 3'd0, 3'd7};
    wait_ack("rb");
    bus.req = '0;
`ifdef ADDER_OUTPUT_SCHEDULER_READBACK_EN
    check("rb_err_set", 32'(bus.err), 32'd1);
    repeat (3) @(negedge clk);
    check("rb_err_sticky", 32'(bus.err), 32'd1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("rb_err_clr", 32'(bus.err), 32'd0);
    wait_idle("rb");
    @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = '0;
    @(negedge clk);
    check("rb2_rdstrobe", {30'd0, bus.avm_chipselect, bus.avm_write_n}, 32'b11);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("rb2_set_wins", 32'(bus.err), 32'd1);
    a2 = 1;
`else
    check("rb_err_tied", 32'(bus.err), 32'd0);
    a2 = 0;
`endif
    $display("readback test err=%0d (readback build=%0d)", bus.err, a2);
    bad = 1'b0;
    wait_idle("rb_end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/adder_output_scheduler.md
ADDER_OUTPUT_SCHEDULER -- requirements
Module: adder_output_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port named clk, reset port named reset.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (range 2..8).
REQ-003 Parameter DATA_W, default 3, width of the output-port value written to the PIO slave (range 1..32).
REQ-004 Parameter HOLD_CYCLES, default 16, minimum cycles a written value stays before the next grant (range 1..65535).
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 req  in  NUM_REQ  per-requester write request, level, held until ack.
REQ-008 req_data  in  NUM_REQ*DATA_W  requester i value in bits [i*DATA_W +: DATA_W].
REQ-009 ack  out  NUM_REQ  one-cycle pulse to the served requester on completion.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 cur_value  out  DATA_W  shadow of the last value written to the slave.
REQ-012 err  out  1  sticky readback-mismatch flag.
REQ-013 err_clr  in  1  clears err.
REQ-014 avm_address  out  2; avm_chipselect  out  1; avm_write_n  out  1; avm_writedata  out  32: zero-wait-state master to the PIO slave.
REQ-015 avm_readdata  in  32  slave read data, valid combinationally in the same cycle as the read strobe.

Function
REQ-016 States SHALL be IDLE, WRITE, READ, HOLD; reset state IDLE.
REQ-017 IDLE: if any req bit is high, grant one by round-robin (search from last_grant+1, wrapping), latch its req_data, go to WRITE; else stay.
REQ-018 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL NOT abort the transaction.
REQ-019 WRITE (one cycle): avm_chipselect=1, avm_write_n=0, avm_address=0, avm_writedata = latched value zero-extended to 32 bits; cur_value updates to the latched value on the next edge.
REQ-020 After WRITE, go to READ if readback is compiled in, else to HOLD.
REQ-021 READ (one cycle): avm_chipselect=1, avm_write_n=1, avm_address=0; avm_readdata[DATA_W-1:0] != latched value sets err on the next edge.
REQ-022 ack[granted] SHALL pulse high for exactly the first HOLD cycle; all other ack bits stay 0.
REQ-023 HOLD SHALL last exactly HOLD_CYCLES cycles (down-counter), then return to IDLE; no grant occurs during HOLD.
REQ-024 Latency: req sampled high in IDLE at edge n -> WRITE cycle n+1, ack cycle n+2 (n+3 with readback); next grant no earlier than ack cycle + HOLD_CYCLES.
REQ-025 Outside WRITE/READ, master outputs SHALL idle at chipselect=0, write_n=1, address=0, writedata=0.
REQ-026 err_clr and a mismatch in the same cycle: set SHALL win (err stays 1).
REQ-027 last_grant SHALL update only on grant; with one requester active it is re-granted every round.

Reset
REQ-028 Reset SHALL force state IDLE, last_grant = NUM_REQ-1 (requester 0 first priority), ack=0, busy=0, cur_value=0, err=0, hold counter 0, master outputs idle.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no ack and no further bus cycle.

Configuration
REQ-030 Macro ADDER_OUTPUT_SCHEDULER_READBACK_EN defined: READ state and err logic present as REQ-021.
REQ-031 Macro undefined: READ state absent, WRITE goes directly to HOLD, err tied 0, err_clr and avm_readdata unused; ports remain.

Verification
REQ-032 After reset, req=4'b0001, value 3'd5 -> one write cycle with writedata=32'h5, ack=4'b0001 at the stated latency, cur_value=5.
REQ-033 req=4'b1111 held, HOLD_CYCLES=4 -> grants in order 0,1,2,3,0, consecutive write strobes exactly 4 cycles apart after each ack (plus bus cycles).
REQ-034 Requester 2 pulses req for one cycle during HOLD and drops it -> never granted, no ack[2].
REQ-035 Readback build, slave model returns 3'd0 for write 3'd7 -> err=1 after READ, stays 1 until err_clr; err_clr coincident with new mismatch -> err stays 1.
REQ-036 reset asserted during HOLD and during WRITE -> next cycle IDLE, busy=0, no ack, master outputs idle, cur_value=0.
